keypad_scanner: RTL
===================

# keypad_scanner

- Column-drive and key-decode end of the 4x4 lock keypad interface.
- Drives one keypad column at a time and samples the four synchronized row lines.
- Debounces a detected press, then emits a 4-bit key code with a one-cycle valid strobe for the lock controller.
- Tracks the held key until a debounced release, then resumes scanning.

## Interface
Parameters:
- SCAN_DIV, 4096: clock cycles per column slot; must be at least 2.
- DEBOUNCE, 8: consecutive qualifying tick samples needed to accept a press or a release; must be at least 1.
- REPEAT_DELAY, 64: ticks held before the first auto-repeat. Used only with the macro.
- REPEAT_RATE, 16: ticks between later auto-repeats. Used only with the macro.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- Row  in  4  keypad rows, active-high, already synchronous to clock.
- Col  out  4  one-hot, active-high column drive.
- key_code  out  4  last accepted key, encoded {col_idx[1:0], row_idx[1:0]}.
- key_valid  out  1  one-cycle strobe when key_code is updated.
- key_held  out  1  high while an accepted key has not been released.

## Operation
Reset:
- Col=4'b0001, key_code=0, key_valid=0, key_held=0.
- State SCAN, divider=0, all counters 0.

Divider and tick:
- Divider counts 0..SCAN_DIV-1 continuously and wraps to 0.
- "Tick" is the cycle with divider==SCAN_DIV-1.
- Row is sampled only on ticks; the earlier cycles of each slot are settle time.

Row selection:
- If several Row bits are set, the lowest set bit is selected (priority encoder).
- The lower column wins only by being scanned first.

SCAN:
- Tick with Row==0: rotate Col left (0001, 0010, 0100, 1000, back to 0001).
- Tick with Row!=0: capture col_idx and row_idx, set press_cnt=1, freeze Col, enter PRESS.
- If DEBOUNCE==1, accept immediately instead of entering PRESS.

PRESS:
- At each tick, if Row[row_idx]==1, press_cnt increments.
- When press_cnt reaches DEBOUNCE: load key_code, assert key_valid, set key_held=1, enter HELD.
- If Row[row_idx]==0 at a tick: clear press_cnt, rotate Col, return to SCAN. No strobe.

HELD:
- At each tick, Row[row_idx]==0 increments rel_cnt; Row[row_idx]==1 clears rel_cnt.
- When rel_cnt reaches DEBOUNCE: key_held=0, rotate Col, return to SCAN.
- Other row bits are ignored while in HELD.

General:
- key_code holds its value until the next accepted key.
- Counter widths are $clog2 of their limit, minimum 1 bit; counters saturate and never wrap.

## Timing
- Latency: key_valid is registered and asserts on the clock edge after the tick where press_cnt reaches DEBOUNCE.
- That is (DEBOUNCE-1)*SCAN_DIV+1 cycles after the first detecting tick.
- key_code is valid in the same cycle as key_valid.
- key_held rises in the key_valid cycle and falls on the edge after the DEBOUNCE-th release tick.
- Col changes only on the edge following a tick.
- Reset overrides everything, including reset mid-PRESS or mid-HELD: all reset values hold from the next edge and no strobe is emitted.
- A press landing during rotation is sampled in the next slot for its column, never in a partial slot.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In HELD, a repeat counter runs while the key stays asserted; it is cleared on any release tick.
  - After REPEAT_DELAY ticks, key_valid pulses again with an unchanged key_code.
  - After that, it pulses every REPEAT_RATE ticks until the release is accepted.
- Undefined:
  - Exactly one key_valid per accepted press.
  - The repeat counter and its logic are absent.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=3.
- Reset, Row=0:
  - all outputs 0, Col=0001.
  - Col=0010 after cycle 4, 0100 after cycle 8, back to 0001 after 16 cycles.
  - key_valid never asserts.
- Stable press at column 2, row 1 (Row=0010 whenever Col==0100):
  - exactly one key_valid with key_code=4'h9 and key_held=1.
  - Col frozen at 0100 while held.
- Bounce (Row=0010 for the first 0100 tick only):
  - no key_valid, Col advances to 1000.
- Release from the HELD state of the stable-press scenario, Row=0:
  - key_held falls 3 ticks (12 cycles) after the release.
  - Col moves to 1000 on the following tick.
- Simultaneous keys at column 0/row 3 and column 1/row 0, stable:
  - key_code=4'h3.
  - The second key is ignored until the first is released.
- Reset asserted in PRESS and again in HELD:
  - reset values appear on the next edge with no strobe.
- With KEYPAD_REPEAT_EN and REPEAT_DELAY=5, REPEAT_RATE=2, key held 12 ticks after acceptance:
  - key_valid pulses after acceptance and at ticks 5, 7, 9, 11, five strobes total.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning 4x4 keypad decoder with debounced press and release.
// Defining KEYPAD_REPEAT_EN adds auto-repeat strobes while a key stays held.
module keypad_scanner #(
   parameter int SCAN_DIV     = 4096,
   parameter int DEBOUNCE     = 8,
   parameter int REPEAT_DELAY = 64,
   parameter int REPEAT_RATE  = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] Row,
   output logic [3:0] Col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

   if (SCAN_DIV < 2 || DEBOUNCE < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
      $error("keypad_scanner: illegal parameter value");
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_DELAY + REPEAT_RATE);
   localparam logic [REP_W-1:0] REP_FIRST  = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] REP_WRAP   = REP_W'(REPEAT_DELAY + REPEAT_RATE - 1);
   localparam logic [REP_W-1:0] REP_RESUME = REP_W'(REPEAT_DELAY);
   logic [REP_W-1:0] rep_cnt;
`endif

   typedef enum logic [1:0] {SCAN, PRESS, HELD} state_t;

   state_t           state;
   logic [DIV_W-1:0] div;
   logic [CNT_W-1:0] press_cnt;
   logic [CNT_W-1:0] rel_cnt;
   logic [1:0]       col_idx;
   logic [1:0]       row_idx;
   logic [1:0]       row_enc;
   logic [1:0]       col_enc;
   logic [3:0]       col_next;
   logic             tick;
   logic             row_hit;

   assign tick     = (div == DIV_LAST);
   assign row_hit  = Row[row_idx];
   assign col_next = {Col[2:0], Col[3]};

   // Lowest set row wins when several keys share the driven column.
   always_comb begin
      row_enc = 2'd0;
      if (Row[0])      row_enc = 2'd0;
      else if (Row[1]) row_enc = 2'd1;
      else if (Row[2]) row_enc = 2'd2;
      else if (Row[3]) row_enc = 2'd3;
   end

   always_comb begin
      col_enc = 2'd0;
      if (Col[0])      col_enc = 2'd0;
      else if (Col[1]) col_enc = 2'd1;
      else if (Col[2]) col_enc = 2'd2;
      else if (Col[3]) col_enc = 2'd3;
   end

   // Rows are only looked at on the last cycle of a slot so the column drive has settled.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= SCAN;
         div       <= '0;
         press_cnt <= '0;
         rel_cnt   <= '0;
         col_idx   <= 2'd0;
         row_idx   <= 2'd0;
         Col       <= 4'b0001;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt   <= '0;
`endif
      end else begin
         key_valid <= 1'b0;
         div       <= tick ? '0 : div + 1'b1;
         if (tick) begin
            unique case (state)
               SCAN: begin
                  if (Row == 4'b0000) begin
                     Col <= col_next;
                  end else begin
                     col_idx <= col_enc;
                     row_idx <= row_enc;
                     if (DEBOUNCE == 1) begin
                        key_code  <= {col_enc, row_enc};
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        rel_cnt   <= '0;
                        state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt   <= '0;
`endif
                     end else begin
                        press_cnt <= CNT_W'(1);
                        state     <= PRESS;
                     end
                  end
               end
               PRESS: begin
                  if (!row_hit) begin
                     press_cnt <= '0;
                     Col       <= col_next;
                     state     <= SCAN;
                  end else if (press_cnt == CNT_LAST) begin
                     press_cnt <= '0;
                     key_code  <= {col_idx, row_idx};
                     key_valid <= 1'b1;
                     key_held  <= 1'b1;
                     rel_cnt   <= '0;
                     state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                     rep_cnt   <= '0;
`endif
                  end else begin
                     press_cnt <= press_cnt + 1'b1;
                  end
               end
               HELD: begin
                  if (row_hit) begin
                     rel_cnt <= '0;
                  end else if (rel_cnt == CNT_LAST) begin
                     rel_cnt  <= '0;
                     key_held <= 1'b0;
                     Col      <= col_next;
                     state    <= SCAN;
                  end else begin
                     rel_cnt <= rel_cnt + 1'b1;
                  end
`ifdef KEYPAD_REPEAT_EN
                  // First repeat after REPEAT_DELAY ticks, then cycle back every REPEAT_RATE ticks.
                  if (!row_hit) begin
                     rep_cnt <= '0;
                  end else if (rep_cnt == REP_FIRST) begin
                     key_valid <= 1'b1;
                     rep_cnt   <= rep_cnt + 1'b1;
                  end else if (rep_cnt == REP_WRAP) begin
                     key_valid <= 1'b1;
                     rep_cnt   <= REP_RESUME;
                  end else begin
                     rep_cnt <= rep_cnt + 1'b1;
                  end
`endif
               end
               default: state <= SCAN;
            endcase
         end
      end
   end

endmodule
